// File: rtl/transmitter_if.sv
// Transmitter host-side bundle: THR write port plus transmitter status and serial line.
//   thr_data   : byte to load into the transmit holding register
//   thr_write  : THR write strobe
//   thr_empty  : THR can accept a write
//   tx_busy    : frame in progress
//   tx_overrun : one-cycle pulse, write attempted while THR full
//   tx_data    : serial output, idle high
// master = host side, slave = transmitter side.
interface transmitter_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] thr_data;
    logic                 thr_write;
    logic                 thr_empty;
    logic                 tx_busy;
    logic                 tx_overrun;
    logic                 tx_data;

    modport master (
        output thr_data, thr_write,
        input  thr_empty, tx_busy, tx_overrun, tx_data
    );

    modport slave (
        input  thr_data, thr_write,
        output thr_empty, tx_busy, tx_overrun, tx_data
    );
endinterface

// File: rtl/transmitter.sv
// UART transmitter with a one-entry holding register (THR) feeding a shift register (TSR).
// Frame: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1); each bit lasts
// OVERSAMPLE bclk cycles. A byte waiting in THR at the end of a stop bit starts the next
// frame with no idle gap.
//   bclk  : clock, OVERSAMPLE x baud rate
//   reset : asynchronous, active-low
//   bus   : transmitter_if slave (thr_data, thr_write, thr_empty, tx_busy, tx_overrun, tx_data)
module transmitter #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 4
) (
    input  logic          bclk,
    input  logic          reset,
    transmitter_if.slave  bus
);
    localparam int unsigned PhaseW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BitW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [PhaseW-1:0]    phase_q, phase_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] thr_q, thr_d;
    logic [DATA_BITS-1:0] tsr_q, tsr_d;
    logic                 thr_empty_q, thr_empty_d;
    logic                 overrun_q, overrun_d;
    logic                 tx_data_q, tx_data_d;
    logic                 phase_last, bit_last, load;

    assign phase_last = (phase_q == PhaseW'(OVERSAMPLE - 1));
    assign bit_last   = (bit_q == BitW'(DATA_BITS - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        thr_d       = thr_q;
        tsr_d       = tsr_q;
        thr_empty_d = thr_empty_q;
        load        = 1'b0;
        tx_data_d   = 1'b1;

        // A write only lands in an empty THR; otherwise it is flagged and dropped.
        if (bus.thr_write && thr_empty_q) begin
            thr_d       = bus.thr_data;
            thr_empty_d = 1'b0;
        end
        overrun_d = bus.thr_write && !thr_empty_q;

        case (state_q)
            StIdle: begin
                if (!thr_empty_q) load = 1'b1;
            end
            StStart: begin
                if (phase_last) begin
                    state_d = StData;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + PhaseW'(1);
                end
            end
            StData: begin
                if (phase_last) begin
                    phase_d = '0;
                    tsr_d   = tsr_q >> 1;
                    if (bit_last) begin
                        state_d = StStop;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    phase_d = phase_q + PhaseW'(1);
                end
            end
            StStop: begin
                if (phase_last) begin
                    if (!thr_empty_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        phase_d = '0;
                    end
                end else begin
                    phase_d = phase_q + PhaseW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
                bit_d   = '0;
            end
        endcase

        // Load uses the THR value held before this edge; a simultaneous write was
        // already rejected above because thr_empty_q was 0.
        if (load) begin
            tsr_d       = thr_q;
            thr_empty_d = 1'b1;
            state_d     = StStart;
            phase_d     = '0;
            bit_d       = '0;
        end

        // Line level is decoded from next state so the flop tracks the state exactly.
        case (state_d)
            StStart: tx_data_d = 1'b0;
            StData:  tx_data_d = tsr_d[0];
            default: tx_data_d = 1'b1;
        endcase
    end

    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            bit_q       <= '0;
            thr_q       <= '0;
            tsr_q       <= '0;
            thr_empty_q <= 1'b1;
            overrun_q   <= 1'b0;
            tx_data_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            thr_q       <= thr_d;
            tsr_q       <= tsr_d;
            thr_empty_q <= thr_empty_d;
            overrun_q   <= overrun_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.thr_empty  = thr_empty_q;
    assign bus.tx_busy    = (state_q != StIdle);
    assign bus.tx_overrun = overrun_q;
    assign bus.tx_data    = tx_data_q;
endmodule
